// File: rtl/fan_pkg.sv
// fan_pkg: shared FSM state encoding and preset index constants for the fan auto-off timer
package fan_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_EXPIRE} state_e;
  localparam logic [1:0] PRE_OFF = 2'd0;
  localparam logic [1:0] PRE_1 = 2'd1;
  localparam logic [1:0] PRE_2 = 2'd2;
  localparam logic [1:0] PRE_3 = 2'd3;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides tick_in by DIV; ports clk, reset_p, en (count enable), clr (sync clear), tick_in, tick_out (same-cycle strobe on wrap)
module tick_prescaler #(
  parameter int DIV = 1000,
  parameter int W = DIV > 1 ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic reset_p,
  input  logic en,
  input  logic clr,
  input  logic tick_in,
  output logic tick_out
);
  logic [W-1:0] cnt_q;
  assign tick_out = en && tick_in && cnt_q == W'(DIV - 1);
  always_ff @(posedge clk)
    if (reset_p || clr) cnt_q <= '0;
    else if (en && tick_in) cnt_q <= tick_out ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/fan_off_timer_ctrl.sv
// fan_off_timer_ctrl: preset-selectable auto-off countdown; inputs tick_usec/fan_on/btn_cycle/btn_cancel, outputs preset_idx/remaining_sec/timer_active/fan_off_p (+warn_p when FAN_OFF_TIMER_WARN_EN is defined)
module fan_off_timer_ctrl
  import fan_pkg::*;
#(
  parameter int US_PER_MS = 1000,
  parameter int MS_PER_SEC = 1000,
  parameter int SEC_W = 15,
  parameter int PRESET1_SEC = 3600,
  parameter int PRESET2_SEC = 10800,
  parameter int PRESET3_SEC = 18000,
  parameter int WARN_SEC = 60
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             tick_usec,
  input  logic             fan_on,
  input  logic             btn_cycle,
  input  logic             btn_cancel,
  output logic [1:0]       preset_idx,
  output logic [SEC_W-1:0] remaining_sec,
  output logic             timer_active,
`ifdef FAN_OFF_TIMER_WARN_EN
  output logic             warn_p,
`endif
  output logic             fan_off_p
);
  if (PRESET1_SEC > (1 << SEC_W) - 1 || PRESET2_SEC > (1 << SEC_W) - 1 || PRESET3_SEC > (1 << SEC_W) - 1) begin : g_bad_preset
    $error("preset exceeds remaining_sec range");
  end
  state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [SEC_W-1:0] rem_q, rem_d;
  logic active_q, off_q, clr, ms_tick, sec_tick;
`ifdef FAN_OFF_TIMER_WARN_EN
  logic warn_q, warn_d;
  assign warn_p = warn_q;
`endif
  assign preset_idx = idx_q;
  assign remaining_sec = rem_q;
  assign timer_active = active_q;
  assign fan_off_p = off_q;
  function automatic logic [SEC_W-1:0] preset_sec(input logic [1:0] i);
    return i == PRE_1 ? SEC_W'(PRESET1_SEC) : i == PRE_2 ? SEC_W'(PRESET2_SEC) : i == PRE_3 ? SEC_W'(PRESET3_SEC) : '0;
  endfunction
  tick_prescaler #(.DIV(US_PER_MS)) u_ms (
    .clk, .reset_p, .en(state_q == ST_RUN), .clr, .tick_in(tick_usec), .tick_out(ms_tick)
  );
  tick_prescaler #(.DIV(MS_PER_SEC)) u_sec (
    .clk, .reset_p, .en(state_q == ST_RUN), .clr, .tick_in(ms_tick), .tick_out(sec_tick)
  );
  // Buttons outrank fan_on and sec_tick; any reload or return to IDLE restarts the prescalers.
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    rem_d = rem_q;
    clr = 1'b0;
`ifdef FAN_OFF_TIMER_WARN_EN
    warn_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE:
        if (!btn_cancel && btn_cycle && fan_on) begin
          state_d = ST_RUN;
          idx_d = PRE_1;
          rem_d = preset_sec(PRE_1);
          clr = 1'b1;
        end
      ST_RUN, ST_PAUSE:
        if (btn_cancel || (btn_cycle && idx_q == PRE_3)) begin
          state_d = ST_IDLE;
          idx_d = PRE_OFF;
          rem_d = '0;
          clr = 1'b1;
        end else if (btn_cycle) begin
          idx_d = idx_q + 2'd1;
          rem_d = preset_sec(idx_q + 2'd1);
          clr = 1'b1;
        end else if (state_q == ST_PAUSE) state_d = fan_on ? ST_RUN : ST_PAUSE;
        else if (!fan_on) state_d = ST_PAUSE;
        else if (sec_tick) begin
          rem_d = rem_q > 1 ? rem_q - 1'b1 : '0;
          state_d = rem_q > 1 ? ST_RUN : ST_EXPIRE;
`ifdef FAN_OFF_TIMER_WARN_EN
          warn_d = rem_q == SEC_W'(WARN_SEC + 1);
`endif
        end
      ST_EXPIRE: begin
        state_d = ST_IDLE;
        idx_d = PRE_OFF;
        rem_d = '0;
        clr = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset_p) begin
      state_q <= ST_IDLE;
      idx_q <= PRE_OFF;
      rem_q <= '0;
      active_q <= 1'b0;
      off_q <= 1'b0;
`ifdef FAN_OFF_TIMER_WARN_EN
      warn_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      rem_q <= rem_d;
      active_q <= state_d == ST_RUN || state_d == ST_PAUSE;
      off_q <= state_d == ST_EXPIRE;
`ifdef FAN_OFF_TIMER_WARN_EN
      warn_q <= warn_d;
`endif
    end
endmodule

// File: tb/tb_fan_off_timer_ctrl.sv
// tb_fan_off_timer_ctrl: directed scenarios plus randomized run against a behavioural model of the auto-off timer
module tb_fan_off_timer_ctrl;
  localparam int SW = 15;
  localparam int SEC_US = 20;
  localparam int WARN = 2;
  logic clk = 0, reset_p = 1, tick_usec = 0, fan_on = 0, btn_cycle = 0, btn_cancel = 0;
  logic [1:0] preset_idx;
  logic [SW-1:0] remaining_sec;
  logic timer_active, fan_off_p;
`ifdef FAN_OFF_TIMER_WARN_EN
  logic warn_p;
`endif
  int errors = 0, checks = 0;
  logic ph = 0, last_tick = 0;
  int m_mode = 0, m_idx = 0, m_rem = 0, m_us = 0, m_off = 0, m_warn = 0;
  int n;
  int pre[4] = '{0, 3, 5, 7};
  always #5 clk = ~clk;
  fan_off_timer_ctrl #(
    .US_PER_MS(4), .MS_PER_SEC(5), .SEC_W(SW),
    .PRESET1_SEC(3), .PRESET2_SEC(5), .PRESET3_SEC(7), .WARN_SEC(WARN)
  ) dut (
    .clk(clk), .reset_p(reset_p), .tick_usec(tick_usec), .fan_on(fan_on),
    .btn_cycle(btn_cycle), .btn_cancel(btn_cancel), .preset_idx(preset_idx),
    .remaining_sec(remaining_sec), .timer_active(timer_active),
`ifdef FAN_OFF_TIMER_WARN_EN
    .warn_p(warn_p),
`endif
    .fan_off_p(fan_off_p)
  );
  task automatic model_idle();
    m_mode = 0; m_idx = 0; m_rem = 0; m_us = 0;
  endtask
  task automatic model_load(input int i);
    m_idx = i; m_rem = pre[i]; m_us = 0;
  endtask
  // Model: modes 0 idle, 1 run, 2 pause, 3 expire; m_us counts tick_usec pulses within the current second.
  task automatic model_update(input logic cyc, input logic can, input logic t);
    bit sec;
    sec = m_mode == 1 && t && m_us == SEC_US - 1;
    m_off = 0;
    m_warn = 0;
    if (reset_p) begin
      model_idle();
      return;
    end
    if (m_mode == 1 && t) m_us = (m_us + 1) % SEC_US;
    case (m_mode)
      0: if (!can && cyc && fan_on) begin model_load(1); m_mode = 1; end
      1, 2:
        if (can || (cyc && m_idx == 3)) model_idle();
        else if (cyc) model_load(m_idx + 1);
        else if (m_mode == 2) begin if (fan_on) m_mode = 1; end
        else if (!fan_on) m_mode = 2;
        else if (sec) begin
          m_rem = m_rem - 1;
          m_warn = int'(m_rem == WARN);
          if (m_rem == 0) begin m_mode = 3; m_off = 1; end
        end
      default: model_idle();
    endcase
  endtask
  task automatic step(input logic cyc, input logic can);
    btn_cycle = cyc; btn_cancel = can; tick_usec = ph; last_tick = ph; ph = ~ph;
    @(posedge clk);
    model_update(cyc, can, last_tick);
    #1;
    btn_cycle = 0; btn_cancel = 0; tick_usec = 0;
  endtask
  task automatic test_reset();
    reset_p = 1;
    step(0, 0);
    reset_p = 0;
    checks++;
    if ({preset_idx, remaining_sec, timer_active, fan_off_p} !== '0) begin
      errors++;
      $display("FAIL reset: got idx=%0d rem=%0d act=%b off=%b, need all 0", preset_idx, remaining_sec, timer_active, fan_off_p);
    end
  endtask
  task automatic test_basic_expiry();
    int c, warns;
    warns = 0;
    step(0, 1);
    fan_on = 1;
    step(1, 0);
    checks++;
    if (preset_idx !== 2'd1 || remaining_sec !== 15'd3 || timer_active !== 1'b1) begin
      errors++;
      $display("FAIL basic_load: got idx=%0d rem=%0d act=%b, need 1/3/1", preset_idx, remaining_sec, timer_active);
    end
    n = 0;
    for (int k = 1; k <= 3; k++) begin
      c = 0;
      while (remaining_sec == SW'(4 - k) && c < 400) begin
        step(0, 0);
        n += int'(last_tick);
        c++;
`ifdef FAN_OFF_TIMER_WARN_EN
        warns += int'(warn_p);
`endif
      end
      checks++;
      if (remaining_sec !== SW'(3 - k) || n != SEC_US * k) begin
        errors++;
        $display("FAIL basic_dec%0d: got rem=%0d at tick %0d, need rem=%0d at tick %0d", k, remaining_sec, n, 3 - k, SEC_US * k);
      end
    end
    checks++;
    if (fan_off_p !== 1'b1 || timer_active !== 1'b0) begin
      errors++;
      $display("FAIL basic_fire: got off=%b act=%b, need 1/0", fan_off_p, timer_active);
    end
    step(0, 0);
    checks++;
    if (fan_off_p !== 1'b0 || preset_idx !== 2'd0 || timer_active !== 1'b0) begin
      errors++;
      $display("FAIL basic_after: got off=%b idx=%0d act=%b, need 0/0/0", fan_off_p, preset_idx, timer_active);
    end
`ifdef FAN_OFF_TIMER_WARN_EN
    checks++;
    if (warns != 1) begin
      errors++;
      $display("FAIL warn_count: got %0d pulses, need 1", warns);
    end
`endif
  endtask
  task automatic test_preset_cycling();
    int exp_rem[4] = '{3, 5, 7, 0};
    int offs;
    offs = 0;
    step(0, 1);
    fan_on = 1;
    for (int i = 0; i < 4; i++) begin
      step(1, 0);
      offs += int'(fan_off_p);
      checks++;
      if (preset_idx !== 2'((i + 1) % 4) || remaining_sec !== SW'(exp_rem[i])) begin
        errors++;
        $display("FAIL cycle%0d: got idx=%0d rem=%0d, need %0d/%0d", i, preset_idx, remaining_sec, (i + 1) % 4, exp_rem[i]);
      end
      for (int j = 0; j < 9; j++) begin
        step(0, 0);
        offs += int'(fan_off_p);
      end
    end
    checks++;
    if (offs != 0) begin
      errors++;
      $display("FAIL cycle_nofire: got %0d fan_off pulses, need 0", offs);
    end
  endtask
  task automatic test_pause_resume();
    int c, moved;
    step(0, 1);
    fan_on = 1;
    step(1, 0);
    n = 0; c = 0;
    while (n < 10 && c < 100) begin step(0, 0); n += int'(last_tick); c++; end
    fan_on = 0;
    moved = 0;
    for (int i = 0; i < 100; i++) begin
      step(0, 0);
      moved += int'(remaining_sec !== 15'd3 || timer_active !== 1'b1);
    end
    checks++;
    if (moved != 0) begin
      errors++;
      $display("FAIL pause_frozen: got %0d cycles with rem/act changed, need 0", moved);
    end
    fan_on = 1;
    step(0, 0);
    n = 0; c = 0;
    while (remaining_sec == 15'd3 && c < 200) begin step(0, 0); n += int'(last_tick); c++; end
    checks++;
    if (remaining_sec !== 15'd2 || n != 10) begin
      errors++;
      $display("FAIL resume: got rem=%0d after %0d ticks, need 2 after 10", remaining_sec, n);
    end
    step(0, 1);
  endtask
  task automatic test_collisions();
    int c;
    step(0, 1);
    fan_on = 1;
    step(1, 0);
    n = 0; c = 0;
    while (n < SEC_US - 1 && c < 100) begin step(0, 0); n += int'(last_tick); c++; end
    step(0, 0);
    step(1, 0);
    checks++;
    if (preset_idx !== 2'd2 || remaining_sec !== 15'd5) begin
      errors++;
      $display("FAIL collide_reload: got idx=%0d rem=%0d, need 2/5", preset_idx, remaining_sec);
    end
    n = 0; c = 0;
    while (remaining_sec == 15'd5 && c < 200) begin step(0, 0); n += int'(last_tick); c++; end
    checks++;
    if (remaining_sec !== 15'd4 || n != SEC_US) begin
      errors++;
      $display("FAIL collide_restart: got rem=%0d after %0d ticks, need 4 after %0d", remaining_sec, n, SEC_US);
    end
    step(1, 1);
    checks++;
    if (preset_idx !== 2'd0 || remaining_sec !== 15'd0 || timer_active !== 1'b0) begin
      errors++;
      $display("FAIL cancel_and_cycle: got idx=%0d rem=%0d act=%b, need 0/0/0", preset_idx, remaining_sec, timer_active);
    end
  endtask
  task automatic test_reset_mid_run();
    int c, bad;
    step(0, 1);
    fan_on = 1;
    step(1, 0);
    c = 0;
    while (remaining_sec != 15'd2 && c < 200) begin step(0, 0); c++; end
    reset_p = 1;
    step(0, 0);
    reset_p = 0;
    checks++;
    if ({preset_idx, remaining_sec, timer_active, fan_off_p} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got idx=%0d rem=%0d act=%b off=%b, need all 0", preset_idx, remaining_sec, timer_active, fan_off_p);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin step(0, 0); bad += int'(fan_off_p || timer_active); end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_quiet: got %0d active/fire cycles, need 0", bad);
    end
  endtask
  task automatic test_random();
    logic [18:0] exp;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) fan_on = ~fan_on;
      reset_p = $urandom_range(599) == 0;
      step($urandom_range(15) == 0, $urandom_range(47) == 0);
      reset_p = 0;
      exp = {2'(m_idx), 15'(m_rem), m_mode == 1 || m_mode == 2, m_off == 1};
      checks++;
      if ({preset_idx, remaining_sec, timer_active, fan_off_p} !== exp) begin
        errors++;
        $display("FAIL random@%0d: got idx=%0d rem=%0d act=%b off=%b, need idx=%0d rem=%0d act=%b off=%b",
                 i, preset_idx, remaining_sec, timer_active, fan_off_p, exp[18:17], exp[16:2], exp[1], exp[0]);
      end
`ifdef FAN_OFF_TIMER_WARN_EN
      checks++;
      if (warn_p !== 1'(m_warn)) begin
        errors++;
        $display("FAIL random_warn@%0d: got %b, need %0d", i, warn_p, m_warn);
      end
`endif
    end
  endtask
  initial begin
    test_reset();
    test_basic_expiry();
    test_preset_cycling();
    test_pause_resume();
    test_collisions();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
